// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_period_meter
// Description : Measures the period of a slow clock or pulse train (iSig) in
//               iClk cycles. iSig is synchronised, rising edges are detected,
//               and the number of iClk cycles between consecutive rises is
//               reported on oPeriod with a one-cycle oValid strobe. oTimeout
//               flags an input that has stopped for TIMEOUT cycles.
//
//               Optional macro CLOCK_PERIOD_METER_DUTY_EN adds oHigh, the
//               high time of the last measured pulse in iClk cycles.
//
// Ports       : iClk     - system clock
//               nRst     - asynchronous active-low reset
//               iEn      - measurement enable (level)
//               iSig     - asynchronous signal under measurement
//               oPeriod  - last measured period (iClk cycles)
//               oValid   - one-cycle pulse, oPeriod updated this cycle
//               oTimeout - no rising edge seen for TIMEOUT cycles
//               oHigh    - last measured high time (duty build only)
//
// Parameters  : WIDTH    - counter / result width
//               TIMEOUT  - cycles without a rise before oTimeout (>=2, <2^WIDTH)
//
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 32'd1000000
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             iEn,
    input  logic             iSig,
    output logic [WIDTH-1:0] oPeriod,
    output logic             oValid,
    output logic             oTimeout
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    ,
    output logic [WIDTH-1:0] oHigh
`endif
);

    localparam logic [WIDTH-1:0] c_TIMEOUT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_edge;
    logic [WIDTH-1:0] r_cnt;

    logic             w_rise;
    logic             w_start;       // first rise after arming: begin counting
    logic             w_measure;     // rise while measuring: publish period
    logic             w_timeoutHit;  // counter reached TIMEOUT with no rise
    logic             w_cntMax;

    // ------------------------------------------------------------------
    // Input synchroniser and edge flop; free-running regardless of iEn so
    // that the edge history is valid the moment measurement is enabled.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= iSig;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign w_rise   = r_sync2 & ~r_edge;
    assign w_cntMax = &r_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode. Dropping iEn overrides everything,
    // including a rise in the same cycle, so a partial measurement is
    // never published.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext  = r_state;
        w_start      = 1'b0;
        w_measure    = 1'b0;
        w_timeoutHit = 1'b0;
        if (!iEn) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_stateNext = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_start     = 1'b1;
                        w_stateNext = S_MEAS;
                    end
                end
                S_MEAS: begin
                    // A rise coinciding with cnt==TIMEOUT is a valid
                    // measurement, so the rise is tested first.
                    if (w_rise) begin
                        w_measure = 1'b1;
                    end else if (r_cnt == c_TIMEOUT) begin
                        w_timeoutHit = 1'b1;
                        w_stateNext  = S_ARM;
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Period counter and registered outputs. The counter is loaded with 1
    // on a rise so that rises N cycles apart read back exactly N.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_cnt    <= '0;
            oPeriod  <= '0;
            oValid   <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oValid <= w_measure;

            if (!iEn) begin
                r_cnt    <= '0;
                oTimeout <= 1'b0;
            end else if (w_start || w_measure) begin
                r_cnt <= c_ONE;
            end else if (w_timeoutHit) begin
                r_cnt    <= '0;
                oTimeout <= 1'b1;
            end else if (r_state == S_MEAS) begin
                if (!w_cntMax) begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                r_cnt <= '0;
            end

            if (w_measure) begin
                oPeriod  <= r_cnt;
                oTimeout <= 1'b0;
            end
        end
    end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    // ------------------------------------------------------------------
    // High-time counter: restarts at each rise, counts while the
    // synchronised input stays high, and is published on the fall.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_hcnt;
    logic             w_fall;
    logic             w_inMeas;

    assign w_fall   = ~r_sync2 & r_edge;
    assign w_inMeas = iEn && (r_state == S_MEAS);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_hcnt <= '0;
            oHigh  <= '0;
        end else begin
            if (w_start || w_measure) begin
                r_hcnt <= c_ONE;
            end else if (w_inMeas && r_sync2 && !(&r_hcnt)) begin
                r_hcnt <= r_hcnt + c_ONE;
            end

            if (w_inMeas && w_fall) begin
                oHigh <= r_hcnt;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Reader side of the divided-clock path: takes a slow clock or pulse train (e.g. a clock-divider output or an external strobe) on iSig.
- Measures its period in iClk cycles and presents the result with a one-cycle valid strobe.
- Used for self-check of generated clocks, and for frequency readout to the processor via a memory-mapped register.
- Includes a timeout flag for stopped or absent inputs.

Parameters:
WIDTH, 32, width of period counter and result registers
TIMEOUT, 32'd1000000, iClk cycles without a rising edge before oTimeout asserts; must be >= 2 and < 2^WIDTH

Ports:
iClk  input  1  system clock
nRst  input  1  reset, asynchronous, active-low
iEn  input  1  measurement enable, level
iSig  input  1  asynchronous signal under measurement
oPeriod  output  WIDTH  last measured period in iClk cycles
oValid  output  1  one-cycle pulse; oPeriod updated this cycle
oTimeout  output  1  level; no rising edge seen for TIMEOUT cycles
oHigh  output  WIDTH  last measured high time in iClk cycles (present only with CLOCK_PERIOD_METER_DUTY_EN)

Behaviour:
- Reset (nRst low, asynchronous): sync flops, edge flop, counter, oPeriod, oValid, oTimeout, oHigh all 0; state IDLE.
- Input path: iSig -> 2-flop synchronizer -> edge flop.
  - rise = sync2 & ~edge; fall = ~sync2 & edge.
  - Edge detection latency: 3 iClk rising edges after the iSig transition.
  - Synchronizer and edge flop run regardless of iEn.
- Counter: cnt, WIDTH bits.
  - Increments only in MEAS.
  - Saturates at all-ones; never wraps.
- States:
  - IDLE:
    - iEn=0 -> stay; cnt=0, oValid=0, oTimeout=0; oPeriod/oHigh hold.
    - iEn=1 -> ARM next cycle.
  - ARM:
    - Wait for rise; cnt held 0.
    - On rise: cnt<=1, -> MEAS. No oValid on the first edge.
  - MEAS:
    - Each cycle without rise: cnt<=cnt+1.
    - On rise: oPeriod<=cnt, oValid<=1 for one cycle, oTimeout<=0, cnt<=1, stay in MEAS.
    - Rises detected at cycles t and t+N give oPeriod=N.
    - If cnt==TIMEOUT and no rise this cycle: oTimeout<=1, cnt<=0, -> ARM, no oValid.
    - If rise and cnt==TIMEOUT in the same cycle: rise wins (measurement, no timeout).
- iEn deasserted in any state -> IDLE next cycle. Any in-progress measurement is discarded (no oValid) and oTimeout clears.
- oValid is registered. It is asserted the cycle after the rise-detect cycle and is never high two consecutive cycles unless rises are 1 cycle apart. That is impossible through the synchronizer, so the minimum period reported is 2.
- oTimeout stays high until the next oValid or until iEn goes low.
- Reset mid-measurement: immediate return to reset values. The next measurement requires iEn=1, then two rises.

Optional Feature:
CLOCK_PERIOD_METER_DUTY_EN
- Defined: adds oHigh and a second counter hcnt.
  - hcnt is loaded with 1 on rise and increments in MEAS while sync2=1.
  - On fall in MEAS: oHigh<=hcnt.
  - oHigh resets to 0 and holds in IDLE/ARM.
  - Fall in ARM is ignored.
- Not defined: oHigh port and hcnt absent; all other behaviour identical.

Test Plan:
1. Reset mid-run: iEn=1, 8-cycle square wave, pull nRst low between edges -> oPeriod=0, oValid=0, oTimeout=0 immediately. After release, first oValid comes only after two further rises.
2. iEn=1, iSig square wave with 8-cycle period (4 high/4 low) -> no oValid on first rise, then oValid pulses every 8 cycles with oPeriod=8.
3. Period change 8 -> 20 cycles -> subsequent oValid pulses 20 cycles apart with oPeriod=20; no spurious pulse at the switch.
4. TIMEOUT=16: one rise, then iSig held low -> oTimeout=1 exactly 16 cycles after the rise-detect cycle, no oValid. Resume 8-cycle wave -> first oValid after the second rise with oPeriod=8 and oTimeout=0.
5. iEn dropped 3 cycles after a rise, re-raised 10 cycles later -> no oValid while low, oTimeout=0, oPeriod holds previous value (8). Normal pulses resume after two rises.
6. With CLOCK_PERIOD_METER_DUTY_EN, wave 3 high/5 low -> oHigh=3 after each fall, oPeriod=8. Without the macro, the same bench minus oHigh passes unchanged.
